prog_loader: RTL
================

# prog_loader

Load-and-run controller that sits directly upstream of the processor core. It accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them sequentially into the core's instruction memory. It holds the core in reset while loading, releases it to execute, and counts execution cycles until the core raises `done`. It then re-parks the core and reports completion status to the bench or host.

## Interface
Parameters:
- `D`, 12: instruction-memory address width; must match the core's program-counter width.
- `W`, 9: machine-code word width.
- `TMO`, 4096: watchdog limit in run cycles; only used when the watchdog is compiled in.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load session; sampled only in IDLE and HALT.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  W  machine-code word.
- `ld_last`  in  1  qualifies `ld_data` as the final word of the program.
- `ld_ready`  out  1  word accepted this cycle when high together with `ld_valid`.
- `im_wr_en`  out  1  instruction-memory write strobe.
- `im_wr_addr`  out  D  instruction-memory write address.
- `im_wr_data`  out  W  instruction-memory write data.
- `core_reset`  out  1  reset into the core (PC and core state).
- `core_done`  in  1  the core's `done` output.
- `busy`  out  1  high in LOAD, ARM and RUN.
- `finished`  out  1  program ended through `core_done`.
- `overflow`  out  1  program image exceeded 2^D words.
- `timeout`  out  1  watchdog expired.
- `cycle_count`  out  16  number of RUN cycles in the last or current run.

## Operation
- States: IDLE, LOAD, ARM, RUN, HALT. State and all outputs are registered. `ld_ready` is the only output decoded from state.
- Reset values:
  - State = IDLE.
  - `core_reset` = 1.
  - `ld_ready`, `im_wr_en`, `busy`, `finished`, `overflow`, `timeout` = 0.
  - `im_wr_addr`, `im_wr_data`, `cycle_count` = 0.
- IDLE: `core_reset` = 1. When `start` = 1, go to LOAD, clear the address counter and `cycle_count`, and clear all status flags.
- LOAD:
  - `ld_ready` = 1.
  - Each accepted word (`ld_valid` & `ld_ready`) is written at the current address, then the address increments by 1.
  - Accepted word with `ld_last` = 1: go to ARM.
  - Accepted word at address 2^D-1 with `ld_last` = 0: that word is still written, `overflow` is set, and the state goes to HALT. The address does not wrap.
  - Idle cycles (`ld_valid` = 0) are allowed without limit.
- ARM: a single cycle. `ld_ready` = 0 and `core_reset` is still 1. This cycle carries the write strobe of the final word. Go to RUN.
- RUN:
  - `core_reset` = 0.
  - `cycle_count` increments every RUN cycle and saturates at 0xFFFF.
  - `core_done` = 1: go to HALT and set `finished`.
- HALT:
  - `core_reset` = 1 and `busy` = 0. `cycle_count` and the flags hold.
  - `start` = 1 begins a new load session exactly as from IDLE.
- `start` is ignored in LOAD, ARM and RUN.
- `ld_data` and `ld_last` are ignored whenever `ld_ready` = 0.
- Flag exclusivity: at most one of `finished`, `overflow` and `timeout` is set per session. If `core_done` and the watchdog fire in the same cycle, `finished` wins.
- An asynchronous reset in any state aborts immediately to the reset values. Partially written instruction memory is left as-is.

## Timing
- Write latency: a word accepted at edge N drives `im_wr_en` = 1 with its address and data during cycle N..N+1. The memory commits it at edge N+1.
- Back-to-back acceptance is allowed: one word per cycle, with an unbroken strobe train.
- The last word is accepted at edge N. ARM occupies N..N+1, and `core_reset` falls at edge N+2. The final memory write (edge N+1) therefore completes before the core leaves reset.
- `cycle_count` is 1 after the first RUN cycle.
- `core_done` sampled high at edge M makes `core_reset` rise and `finished` set at edge M.

## Configuration
- `PROG_LOADER_WATCHDOG_EN` defined:
  - RUN compares `cycle_count` against `TMO`.
  - When a RUN cycle would make `cycle_count` equal `TMO` and `core_done` = 0, go to HALT with `timeout` = 1.
- Not defined: no run limit. `timeout` is tied to 0, `TMO` is unused, and a run that never completes stays in RUN until reset.

## Test plan
- Nominal load: `start`, then 5 back-to-back words 0x101..0x105 with `ld_last` on the 5th → writes at addresses 0..4 with matching data, one per cycle. `core_reset` falls 2 cycles after the last acceptance.
- Throttled loader: `ld_valid` toggling every other cycle for 4 words → 4 writes, no gaps or duplicates in addresses, `ld_ready` held 1 throughout LOAD.
- Completion: `core_done` driven high 10 cycles into RUN → `finished` = 1, `cycle_count` = 10, `core_reset` = 1. A later `start` clears `finished` and `cycle_count` to 0.
- Overflow with D = 3: 8 words with no `ld_last` → 8 writes at addresses 0..7, `overflow` = 1, state HALT, `core_reset` held 1.
- Watchdog with the macro defined and TMO = 20, `core_done` never asserted → `timeout` = 1 and `cycle_count` = 20. Without the macro the run is still in RUN after 100 cycles with `timeout` = 0.
- `reset` asserted mid-LOAD and mid-RUN → all outputs go to their reset values immediately, before the next clock edge. `start` during RUN is ignored.

Source files
------------

// File: rtl/prog_loader.sv
// Load-and-run controller: streams machine-code words into instruction memory,
// releases the core, counts run cycles until done. Optional watchdog: PROG_LOADER_WATCHDOG_EN.
module prog_loader #(
  parameter int D   = 12,
  parameter int W   = 9,
  parameter int TMO = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         ld_valid,
  input  logic [W-1:0] ld_data,
  input  logic         ld_last,
  output logic         ld_ready,
  output logic         im_wr_en,
  output logic [D-1:0] im_wr_addr,
  output logic [W-1:0] im_wr_data,
  output logic         core_reset,
  input  logic         core_done,
  output logic         busy,
  output logic         finished,
  output logic         overflow,
  output logic         timeout,
  output logic [15:0]  cycle_count
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, HALT} state_t;

`ifdef PROG_LOADER_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  state_t       state;
  state_t       state_nx;
  logic [D-1:0] addr;
  logic [15:0]  cnt_inc;
  logic         accept;
  logic         at_top;
  logic         wd_fire;
  logic         sess_start;

  assign accept     = (state == LOAD) && ld_valid;
  assign at_top     = (addr == {D{1'b1}});
  assign sess_start = ((state == IDLE) || (state == HALT)) && start;
  assign cnt_inc    = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
  // The watchdog trips on the RUN cycle that would bring the count up to TMO.
  assign wd_fire    = WD_EN && (state == RUN) && !core_done && (cnt_inc == 16'(TMO));

  // ld_ready is the only output decoded directly from state.
  assign ld_ready = (state == LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every branch starts from a default so this block never infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, HALT: if (start) state_nx = LOAD;
      LOAD: begin
        if (accept) begin
          if (ld_last)     state_nx = ARM;
          else if (at_top) state_nx = HALT;
        end
      end
      ARM:     state_nx = RUN;
      RUN:     if (core_done || wd_fire) state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr        <= '0;
      im_wr_en    <= 1'b0;
      im_wr_addr  <= '0;
      im_wr_data  <= '0;
      core_reset  <= 1'b1;
      busy        <= 1'b0;
      finished    <= 1'b0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      im_wr_en   <= accept;
      busy       <= (state_nx == LOAD) || (state_nx == ARM) || (state_nx == RUN);
      // The core leaves reset one cycle after RUN is entered, so the final
      // write issued during ARM has committed before the core fetches.
      core_reset <= !((state == RUN) && (state_nx == RUN));

      if (sess_start) begin
        addr        <= '0;
        cycle_count <= '0;
        finished    <= 1'b0;
        overflow    <= 1'b0;
        timeout     <= 1'b0;
      end

      if (accept) begin
        im_wr_addr <= addr;
        im_wr_data <= ld_data;
        if (!at_top) addr <= addr + 1'b1;
        if (at_top && !ld_last) overflow <= 1'b1;
      end

      if (state == RUN) begin
        cycle_count <= cnt_inc;
        if (core_done)    finished <= 1'b1;
        else if (wd_fire) timeout  <= 1'b1;
      end
    end
  end

endmodule
